// File: rtl/ahb_mem_sub_if.sv
// AHB bus bundle between the decoder/mux side and ahb_mem_sub.
// ready is the mux-level ready; readyOut is this subordinate's own completion output.
interface ahb_mem_sub_if #(
  parameter int DataWidth = 32,
  parameter int AddrWidth = 32
);
  logic                   sel;
  logic [AddrWidth-1:0]   addr;
  logic                   write;
  logic [2:0]             size;
  logic [1:0]             trans;
  logic [DataWidth-1:0]   wData;
  logic [DataWidth/8-1:0] wStrb;
  logic                   ready;
  logic                   readyOut;
  logic                   resp;
  logic [DataWidth-1:0]   rData;

  modport master (output sel, addr, write, size, trans, wData, wStrb, ready,
                  input  readyOut, resp, rData);
  modport slave  (input  sel, addr, write, size, trans, wData, wStrb, ready,
                  output readyOut, resp, rData);
endinterface

// File: rtl/ahb_mem_sub.sv
// SRAM-backed AHB subordinate: programmable wait states, byte-lane writes,
// two-cycle ERROR response and write-to-read forwarding for pipelined reads.
module ahb_mem_sub #(
  parameter int                   DataWidth  = 32,
  parameter int                   AddrWidth  = 32,
  parameter int                   Depth      = 256,
  parameter logic [AddrWidth-1:0] BaseAddr   = {AddrWidth{1'b0}},
  parameter int                   WaitStates = 0
) (
  input logic          clk,
  input logic          reset,
  ahb_mem_sub_if.slave bus
);
  localparam int                 Bytes    = DataWidth / 8;
  localparam int                 OffW     = $clog2(Bytes);
  localparam int                 IdxW     = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [AddrWidth:0] LoAddr   = {1'b0, BaseAddr};
  localparam logic [AddrWidth:0] HiAddr   = LoAddr + (AddrWidth + 1)'(Depth * Bytes);
  localparam logic [3:0]         WaitInit = 4'(WaitStates);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DONE = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  state_e               state_r;
  logic [3:0]           wait_cnt_r;
  logic                 readyout_r;
  logic                 resp_r;
  logic [DataWidth-1:0] rdata_r;
  logic [IdxW-1:0]      idx_r;
  logic [Bytes-1:0]     lane_r;
  logic                 write_r;
  logic [DataWidth-1:0] mem_r [Depth];

  logic                 accept_s;
  logic                 err_s;
  logic [AddrWidth-1:0] rel_s;
  logic [AddrWidth-1:0] align_mask_s;
  logic [7:0]           size_mask_s;
  logic [IdxW-1:0]      acc_idx_s;
  logic [Bytes-1:0]     acc_lane_s;
  logic                 commit_s;
  logic [Bytes-1:0]     wen_s;
  logic [IdxW-1:0]      rd_idx_s;
  logic [DataWidth-1:0] rd_word_s;

  function automatic logic [DataWidth-1:0] merge_lanes(input logic [DataWidth-1:0] old_word,
                                                        input logic [DataWidth-1:0] new_word,
                                                        input logic [Bytes-1:0]     en);
    logic [DataWidth-1:0] res;
    res = old_word;
    for (int b = 0; b < Bytes; b++) begin
      res[8*b +: 8] = en[b] ? new_word[8*b +: 8] : old_word[8*b +: 8];
    end
    return res;
  endfunction

  // Address-phase decode, error check and forwarded read word.
  always_comb begin
    accept_s     = bus.sel & bus.ready & bus.trans[1] & readyout_r;
    rel_s        = bus.addr - BaseAddr;
    acc_idx_s    = IdxW'(rel_s >> OffW);
    align_mask_s = (AddrWidth'(1) << bus.size) - AddrWidth'(1);
    case (bus.size)
      3'd0:    size_mask_s = 8'h01;
      3'd1:    size_mask_s = 8'h03;
      3'd2:    size_mask_s = 8'h0F;
      3'd3:    size_mask_s = 8'hFF;
      default: size_mask_s = 8'hFF;
    endcase
    acc_lane_s = Bytes'(size_mask_s) << (rel_s & AddrWidth'(Bytes - 1));
    err_s      = ({1'b0, bus.addr} < LoAddr) | ({1'b0, bus.addr} >= HiAddr)
               | ((bus.addr & align_mask_s) != {AddrWidth{1'b0}})
               | (int'(bus.size) > OffW);
    // A write retiring at the same edge a read loads its data must be merged in.
    commit_s  = (state_r == S_DONE) & write_r & ~reset;
    wen_s     = lane_r & bus.wStrb;
    rd_idx_s  = (state_r == S_WAIT) ? idx_r : acc_idx_s;
    rd_word_s = (commit_s && (rd_idx_s == idx_r)) ? merge_lanes(mem_r[rd_idx_s], bus.wData, wen_s)
                                                  : mem_r[rd_idx_s];
  end

  // Transfer FSM with registered readyOut/resp/rData.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r    <= S_IDLE;
      wait_cnt_r <= 4'd0;
      readyout_r <= 1'b1;
      resp_r     <= 1'b0;
      rdata_r    <= {DataWidth{1'b0}};
      idx_r      <= {IdxW{1'b0}};
      lane_r     <= {Bytes{1'b0}};
      write_r    <= 1'b0;
    end else begin
      rdata_r <= {DataWidth{1'b0}};
      case (state_r)
        S_IDLE, S_DONE, S_ERR2: begin
          if (accept_s && err_s) begin
            state_r    <= S_ERR1;
            readyout_r <= 1'b0;
            resp_r     <= 1'b1;
            write_r    <= 1'b0;
          end else if (accept_s) begin
            idx_r   <= acc_idx_s;
            lane_r  <= acc_lane_s;
            write_r <= bus.write;
            resp_r  <= 1'b0;
            if (WaitStates == 0) begin
              state_r    <= S_DONE;
              readyout_r <= 1'b1;
              rdata_r    <= bus.write ? {DataWidth{1'b0}} : rd_word_s;
            end else begin
              state_r    <= S_WAIT;
              readyout_r <= 1'b0;
              wait_cnt_r <= WaitInit;
            end
          end else begin
            state_r    <= S_IDLE;
            readyout_r <= 1'b1;
            resp_r     <= 1'b0;
            write_r    <= 1'b0;
          end
        end
        S_WAIT: begin
          if (wait_cnt_r <= 4'd1) begin
            state_r    <= S_DONE;
            readyout_r <= 1'b1;
            wait_cnt_r <= 4'd0;
            rdata_r    <= write_r ? {DataWidth{1'b0}} : rd_word_s;
          end else begin
            wait_cnt_r <= wait_cnt_r - 4'd1;
          end
        end
        S_ERR1: begin
          state_r    <= S_ERR2;
          readyout_r <= 1'b1;
          resp_r     <= 1'b1;
        end
        default: begin
          state_r    <= S_IDLE;
          readyout_r <= 1'b1;
          resp_r     <= 1'b0;
          write_r    <= 1'b0;
        end
      endcase
    end
  end

  // Byte-lane commit at the end of the completing cycle; storage is never reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < Bytes; b++) begin
      if (commit_s && wen_s[b]) begin
        mem_r[idx_r][8*b +: 8] <= bus.wData[8*b +: 8];
      end
    end
  end

  assign bus.readyOut = readyout_r;
  assign bus.resp     = resp_r;
  assign bus.rData    = rdata_r;
endmodule

// File: tb/tb_ahb_mem_sub.sv
// Directed bench for ahb_mem_sub: three instances with WaitStates 0, 3 and 5
// share one stimulus set; only the targeted instance is selected.
module tb_ahb_mem_sub;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [2:0]  selv = 3'b000;
  logic [31:0] addr_t = 32'h0;
  logic        write_t = 1'b0;
  logic [2:0]  size_t = 3'd2;
  logic [1:0]  trans_t = 2'd0;
  logic [31:0] wdata_t = 32'h0;
  logic [3:0]  wstrb_t = 4'hF;
  logic [1:0]  tgt = 2'd0;
  logic        ro_s;
  logic        rs_s;
  logic [31:0] rd_s;
  int          vec = 0;
  int          errs = 0;

  ahb_mem_sub_if #(.DataWidth(32), .AddrWidth(32)) bus0 ();
  ahb_mem_sub_if #(.DataWidth(32), .AddrWidth(32)) bus3 ();
  ahb_mem_sub_if #(.DataWidth(32), .AddrWidth(32)) bus5 ();

  assign bus0.sel = selv[0];
  assign bus3.sel = selv[1];
  assign bus5.sel = selv[2];
  assign {bus0.addr, bus0.write, bus0.size, bus0.trans, bus0.wData, bus0.wStrb} = {addr_t, write_t, size_t, trans_t, wdata_t, wstrb_t};
  assign {bus3.addr, bus3.write, bus3.size, bus3.trans, bus3.wData, bus3.wStrb} = {addr_t, write_t, size_t, trans_t, wdata_t, wstrb_t};
  assign {bus5.addr, bus5.write, bus5.size, bus5.trans, bus5.wData, bus5.wStrb} = {addr_t, write_t, size_t, trans_t, wdata_t, wstrb_t};
  assign bus0.ready = bus0.readyOut;
  assign bus3.ready = bus3.readyOut;
  assign bus5.ready = bus5.readyOut;

  ahb_mem_sub #(.WaitStates(0)) u_dut0 (.clk(clk), .reset(reset), .bus(bus0));
  ahb_mem_sub #(.WaitStates(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));
  ahb_mem_sub #(.WaitStates(5)) u_dut5 (.clk(clk), .reset(reset), .bus(bus5));

  always #5 clk = ~clk;

  always_comb begin
    case (tgt)
      2'd0:    begin ro_s = bus0.readyOut; rs_s = bus0.resp; rd_s = bus0.rData; end
      2'd1:    begin ro_s = bus3.readyOut; rs_s = bus3.resp; rd_s = bus3.rData; end
      default: begin ro_s = bus5.readyOut; rs_s = bus5.resp; rd_s = bus5.rData; end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    selv = 3'b000; trans_t = 2'd0; write_t = 1'b0; size_t = 3'd2; wstrb_t = 4'hF;
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic w, input logic [2:0] sz, input logic [1:0] tr);
    selv = 3'b001 << tgt; addr_t = a; write_t = w; size_t = sz; trans_t = tr;
  endtask

  task automatic test_reset();
    reset = 1'b1; idle_bus(); step(); step(); reset = 1'b0;
    for (int t = 0; t < 3; t++) begin
      tgt = 2'(t); #1;
      vec++; if (ro_s !== 1'b1) begin errs++; $display("FAIL reset_ready dut=%0d got=%b exp=1", t, ro_s); end
      vec++; if (rs_s !== 1'b0) begin errs++; $display("FAIL reset_resp dut=%0d got=%b exp=0", t, rs_s); end
      vec++; if (rd_s !== 32'h0) begin errs++; $display("FAIL reset_rdata dut=%0d got=%h exp=0", t, rd_s); end
    end
    tgt = 2'd0;
    for (int tr = 0; tr < 2; tr++) begin
      addr_phase(32'h10, 1'b0, 3'd2, 2'(tr)); step();
      vec++; if (ro_s !== 1'b1 || rs_s !== 1'b0) begin errs++; $display("FAIL idle_busy_okay trans=%0d got=%b/%b exp=1/0", tr, ro_s, rs_s); end
    end
    idle_bus(); step();
  endtask

  task automatic test_word_ws0();
    tgt = 2'd0;
    addr_phase(32'h10, 1'b1, 3'd2, 2'd2); step();
    vec++; if (ro_s !== 1'b1 || rs_s !== 1'b0) begin errs++; $display("FAIL ws0_write_done got=%b/%b exp=1/0", ro_s, rs_s); end
    wdata_t = 32'hDEADBEEF; wstrb_t = 4'hF;
    addr_phase(32'h10, 1'b0, 3'd2, 2'd2); step();
    vec++; if (rd_s !== 32'hDEADBEEF) begin errs++; $display("FAIL ws0_forward got=%h exp=deadbeef", rd_s); end
    idle_bus(); step();
    vec++; if (rd_s !== 32'h0) begin errs++; $display("FAIL ws0_rdata_idle got=%h exp=0", rd_s); end
  endtask

  task automatic test_byte_lanes_ws3();
    logic [31:0] a_tab [3]  = '{32'h20, 32'h21, 32'h20};
    logic        w_tab [3]  = '{1'b1, 1'b1, 1'b0};
    logic [2:0]  s_tab [3]  = '{3'd2, 3'd0, 3'd2};
    logic [31:0] d_tab [3]  = '{32'h11223344, 32'hAAAAAAAA, 32'h0};
    tgt = 2'd1;
    for (int i = 0; i < 3; i++) begin
      wdata_t = d_tab[i]; wstrb_t = 4'hF;
      addr_phase(a_tab[i], w_tab[i], s_tab[i], 2'd2); step();
      selv = 3'b000; trans_t = 2'd0;
      for (int c = 0; c < 3; c++) begin
        vec++; if (ro_s !== 1'b0 || rs_s !== 1'b0 || rd_s !== 32'h0) begin
          errs++; $display("FAIL ws3_wait xfer=%0d cyc=%0d got=%b/%b/%h exp=0/0/0", i, c, ro_s, rs_s, rd_s); end
        step();
      end
      vec++; if (ro_s !== 1'b1 || rs_s !== 1'b0) begin errs++; $display("FAIL ws3_done xfer=%0d got=%b/%b exp=1/0", i, ro_s, rs_s); end
      if (!w_tab[i]) begin
        vec++; if (rd_s !== 32'h1122AA44) begin errs++; $display("FAIL ws3_byte_merge got=%h exp=1122aa44", rd_s); end
      end
      step();
    end
  endtask

  task automatic test_error();
    logic [31:0] a_tab [3] = '{32'h400, 32'h3, 32'h8};
    logic [2:0]  s_tab [3] = '{3'd2, 3'd1, 3'd3};
    tgt = 2'd0;
    addr_phase(32'h0, 1'b1, 3'd2, 2'd2); step();
    wdata_t = 32'h01020304; addr_phase(32'h8, 1'b1, 3'd2, 2'd2); step();
    wdata_t = 32'h05060708; idle_bus(); step();
    for (int i = 0; i < 3; i++) begin
      wdata_t = 32'hFFFFFFFF;
      addr_phase(a_tab[i], 1'b1, s_tab[i], 2'd2); step();
      idle_bus();
      vec++; if (ro_s !== 1'b0 || rs_s !== 1'b1 || rd_s !== 32'h0) begin
        errs++; $display("FAIL err1 case=%0d got=%b/%b/%h exp=0/1/0", i, ro_s, rs_s, rd_s); end
      step();
      vec++; if (ro_s !== 1'b1 || rs_s !== 1'b1 || rd_s !== 32'h0) begin
        errs++; $display("FAIL err2 case=%0d got=%b/%b/%h exp=1/1/0", i, ro_s, rs_s, rd_s); end
      step();
      vec++; if (ro_s !== 1'b1 || rs_s !== 1'b0) begin errs++; $display("FAIL err_idle case=%0d got=%b/%b exp=1/0", i, ro_s, rs_s); end
    end
    addr_phase(32'h0, 1'b0, 3'd2, 2'd2); step();
    vec++; if (rd_s !== 32'h01020304) begin errs++; $display("FAIL err_storage_w0 got=%h exp=01020304", rd_s); end
    addr_phase(32'h8, 1'b0, 3'd2, 2'd2); step();
    vec++; if (rd_s !== 32'h05060708) begin errs++; $display("FAIL err_storage_w2 got=%h exp=05060708", rd_s); end
    idle_bus(); step();
  endtask

  task automatic test_reset_mid_wait();
    tgt = 2'd2; wdata_t = 32'hCAFEF00D;
    addr_phase(32'h40, 1'b1, 3'd2, 2'd2); step(); idle_bus();
    for (int c = 0; c < 5; c++) step();
    vec++; if (ro_s !== 1'b1) begin errs++; $display("FAIL ws5_done got=%b exp=1", ro_s); end
    step();
    wdata_t = 32'h0BADBEEF;
    addr_phase(32'h40, 1'b1, 3'd2, 2'd2); step(); idle_bus(); step();
    vec++; if (ro_s !== 1'b0) begin errs++; $display("FAIL ws5_second_wait got=%b exp=0", ro_s); end
    reset = 1'b1; step(); reset = 1'b0;
    vec++; if (ro_s !== 1'b1 || rs_s !== 1'b0 || rd_s !== 32'h0) begin
      errs++; $display("FAIL ws5_reset_idle got=%b/%b/%h exp=1/0/0", ro_s, rs_s, rd_s); end
    addr_phase(32'h40, 1'b0, 3'd2, 2'd2); step(); idle_bus();
    for (int c = 0; c < 5; c++) step();
    vec++; if (rd_s !== 32'hCAFEF00D) begin errs++; $display("FAIL ws5_reset_discard got=%h exp=cafef00d", rd_s); end
    step();
    // Reset landing on a write's completing cycle must drop that write too.
    tgt = 2'd0;
    addr_phase(32'h44, 1'b1, 3'd2, 2'd2); step();
    wdata_t = 32'h12345678; idle_bus(); step();
    addr_phase(32'h44, 1'b1, 3'd2, 2'd2); step();
    wdata_t = 32'hFFFFFFFF; idle_bus(); reset = 1'b1; step(); reset = 1'b0;
    addr_phase(32'h44, 1'b0, 3'd2, 2'd2); step();
    vec++; if (rd_s !== 32'h12345678) begin errs++; $display("FAIL reset_at_done got=%h exp=12345678", rd_s); end
    idle_bus(); step();
  endtask

  task automatic test_back_to_back();
    logic [31:0] d_tab [4] = '{32'hA0A1A2A3, 32'hB0B1B2B3, 32'hC0C1C2C3, 32'hD0D1D2D3};
    tgt = 2'd0;
    for (int i = 0; i <= 8; i++) begin
      if (i < 8) addr_phase(32'((i % 4) * 4), (i < 4), 3'd2, ((i % 4) == 0) ? 2'd2 : 2'd3);
      else idle_bus();
      if (i >= 1 && i <= 4) wdata_t = d_tab[i-1];
      step();
      if (i < 8) begin
        vec++; if (ro_s !== 1'b1 || rs_s !== 1'b0) begin errs++; $display("FAIL burst_done op=%0d got=%b/%b exp=1/0", i, ro_s, rs_s); end
        if (i >= 4) begin
          vec++; if (rd_s !== d_tab[i-4]) begin errs++; $display("FAIL burst_read op=%0d got=%h exp=%h", i, rd_s, d_tab[i-4]); end
        end
      end
    end
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "bench did not terminate");
  end

  initial begin
    test_reset();
    test_word_ws0();
    test_byte_lanes_ws3();
    test_error();
    test_reset_mid_wait();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule

// File: doc/ahb_mem_sub.md
# ahb_mem_sub

Parametrised AHB subordinate with SRAM-backed storage, programmable wait states, byte-lane writes and a two-cycle ERROR response. It sits behind the AHB decoder/mux pair as a generic memory or register-file target. It is the next generation of the common-signal AHB subordinate: configurable width, depth, base address and latency, plus write-to-read forwarding, which the plain subordinate modport does not provide.

## Interface
- DataWidth, 32, data bus width in bits; one of 8, 16, 32, 64.
- AddrWidth, 32, address width in bits.
- Depth, 256, number of DataWidth-wide words.
- BaseAddr, 0, byte base address; must be aligned to Depth*DataWidth/8.
- WaitStates, 0, number of readyOut=0 cycles inserted before each OKAY completion; range 0–15.

Ports:
- clk  in  1  clock; all logic on its rising edge.
- reset  in  1  synchronous, active-high reset.
- sel  in  1  subordinate select from the decoder.
- addr  in  AddrWidth  byte address, sampled in the address phase.
- write  in  1  1 = write, 0 = read.
- size  in  3  transfer size; bytes = 2^size.
- trans  in  2  0 IDLE, 1 BUSY, 2 NONSEQ, 3 SEQ.
- wData  in  DataWidth  write data, valid in the data phase.
- wStrb  in  DataWidth/8  write byte strobes.
- ready  in  1  bus-level ready from the mux.
- readyOut  out  1  transfer-complete output of this subordinate.
- resp  out  1  0 OKAY, 1 ERROR.
- rData  out  DataWidth  read data.

## Operation
- **Address-phase accept.** A transfer is accepted when sel & ready & trans[1] is 1 at a rising edge. The block then latches addr, write and size.
- **IDLE/BUSY.** sel & ready with trans of IDLE or BUSY gets a zero-wait OKAY. No storage access occurs.
- **Error check at accept.** The transfer is in error if any of these holds:
  - addr < BaseAddr, or addr ≥ BaseAddr + Depth*DataWidth/8;
  - addr is not aligned to 2^size;
  - 2^size > DataWidth/8.
- **Word index and byte lanes.**
  - Word index = (addr − BaseAddr) >> log2(DataWidth/8).
  - Lane enable = ((1 << 2^size) − 1) << addr[log2(DataWidth/8)−1:0], ANDed with wStrb.
- **FSM states.**
  - IDLE: readyOut=1, resp=0.
  - WAIT: a counter runs from WaitStates down to 1; readyOut=0, resp=0.
  - DONE: readyOut=1, resp=0; the transfer completes.
  - ERR1: readyOut=0, resp=1.
  - ERR2: readyOut=1, resp=1.
- **FSM transitions.**
  - A good accept goes to WAIT, or straight to DONE if WaitStates=0.
  - A bad accept goes to ERR1, then ERR2. Errors never insert wait states.
  - From DONE or ERR2, a new accept in the same cycle starts the next transfer (pipelined). Otherwise the FSM returns to IDLE.
- **Writes.**
  - wData is sampled in the completing (DONE) cycle.
  - Enabled lanes are committed to storage at the end of that cycle.
  - Errored writes never modify storage.
- **Reads.**
  - rData is valid in the DONE cycle only; it is 0 in all other cycles, including ERROR.
  - Narrow reads return the full word; the manager selects the lanes.
- **Forwarding.** A read whose word index matches a write completing in the read's address-phase cycle returns the merged post-write word. Unwritten lanes come from storage.
- **Storage reset.** Storage contents are not reset.

## Timing
- **Reset.** While reset=1 at an edge, the next state is IDLE:
  - readyOut=1, resp=0, rData=0;
  - the wait counter is cleared;
  - any pending write is discarded, including a reset coinciding with DONE.
- **OKAY latency.** For an accept at edge N, readyOut=0 during cycles N+1..N+WaitStates and readyOut=1 at cycle N+WaitStates+1. With WaitStates=0, every transfer completes in N+1.
- **ERROR latency.** For an accept at edge N, cycle N+1 is ERR1 and N+2 is ERR2.
- **Mid-transfer address phases.** Address phases presented while readyOut=0 are ignored, because ready=0 on the bus.
- **Deselect mid-transfer.** Deasserting sel after accept does not abort the transfer; it completes normally.
- **Back-to-back throughput.** With WaitStates=0, one transfer per cycle is sustained with no bubbles.

## Test plan
- **Reset values.** Assert reset for 2 cycles. Then readyOut=1, resp=0, rData=0, and an IDLE transfer with sel=1 gets an OKAY.
- **Word write/read, WaitStates=0.** Write 0xDEADBEEF to 0x10, then read 0x10 back-to-back (read address phase in the write's data phase). The read returns 0xDEADBEEF via forwarding in cycle N+2.
- **Byte write, WaitStates=3.** Write word 0x11223344 to 0x20. Then write byte 0xAA (size=0) to 0x21 with wStrb=0xF. Read 0x20.
  - Each transfer shows 3 cycles of readyOut=0, then completion.
  - The read returns 0x1122AA44.
- **Error response.** Issue three transfers: addr = BaseAddr + Depth*4 (out of range), a misaligned halfword at 0x3, and size=3 on a 32-bit bus. Each gets readyOut=0/resp=1, then readyOut=1/resp=1. Storage is unchanged on readback.
- **Reset mid-WAIT.** With WaitStates=5, assert reset on the 2nd wait cycle of a write to 0x40. The FSM returns to IDLE, and a later read of 0x40 returns its previous value.
- **Pipelined burst.** Issue a NONSEQ/SEQ×3 burst of writes to 0x0–0xC, then reads, with WaitStates=0. There is one completion per cycle and the data matches.
